mulu_m7q7_host: RTL and testbench
=================================

// Module: mulu_m7q7_host
// PURPOSE
// Host-side initiator for the clock-edge-multiplexed 7x7 unsigned multiplier pinout.
// Accepts an operand pair (m, q) on a valid/ready port and generates the chip clock.
// Drives the operands onto the chip's 7-bit input bus in the phases the chip latches them.
// Captures both product halves from the chip's 7-bit output bus and returns the 14-bit
// product, plus a mismatch flag against a local m*q. Used in the FPGA test harness and
// as the bench driver for the chip top.
// PARAMETERS
// HALF_CYCLES  4  clk cycles per chip-clock phase segment; legal range >= SYNC_STAGES+1
// SYNC_STAGES  2  synchronizer flops on chip_out before sampling; legal range >= 1
// PORTS
// clk        in   1   system clock; all logic is on its rising edge
// rst_n      in   1   asynchronous active-low reset
// op_valid   in   1   operand pair valid
// op_ready   out  1   operand pair accepted when op_valid && op_ready
// op_m       in   7   multiplicand
// op_q       in   7   multiplier
// res_valid  out  1   result valid; held until res_ready
// res_ready  in   1   result consumed when res_valid && res_ready
// res_p      out  14  captured product {hi,lo}
// res_err    out  1   res_p != op_m*op_q (the operands latched at accept)
// chip_clk   out  1   to chip io_in[0]
// chip_in    out  7   to chip io_in[7:1]
// chip_out   in   7   from chip io_out[7:1]; asynchronous to clk
// busy       out  1   FSM not in IDLE
// BEHAVIOUR
// - Chip protocol:
//   - Falling chip_clk edge latches chip_in as m; rising edge latches chip_in as q.
//   - chip_out carries p[6:0] while chip_clk=1 and p[13:7] while chip_clk=0.
// - Reset: chip_clk=1, chip_in=0, op_ready=1, res_valid=0, res_p=0, res_err=0, busy=0, FSM=IDLE.
// - op_ready = (state==IDLE) && !res_valid; on accept, latch op_m/op_q and go to A.
// - Each state A..F lasts exactly HALF_CYCLES clk cycles, counted by a down-counter:
//   A  chip_clk=1  chip_in=m   setup m
//   B  chip_clk=0  chip_in=m   m latched on entry fall
//   C  chip_clk=0  chip_in=q   setup q
//   D  chip_clk=1  chip_in=q   q latched on entry rise; lo <= sync(chip_out) in last cycle
//   E  chip_clk=1  chip_in=m   setup m
//   F  chip_clk=0  chip_in=m   m re-latched on entry fall; hi <= sync(chip_out) in last cycle
//   DONE  chip_clk=1, chip_in held at m, res_valid=1, res_p={hi,lo}, res_err registered
// - chip_clk and chip_in are driven straight from flops (glitch-free); chip_in changes only
//   on the cycle the chip_clk level holds, never on the same cycle as a chip_clk edge.
// - chip_out passes through SYNC_STAGES flops; sampling in the last cycle of D/F sees data
//   that has been stable for >= 1 cycle.
// - Latency: accept cycle -> res_valid high = 6*HALF_CYCLES+1 cycles.
// - DONE -> IDLE on res_valid && res_ready. res_valid/res_p/res_err stay stable while stalled.
//   A new op is accepted no earlier than the cycle after the handshake.
// - op_valid while busy is ignored (op_ready=0). op_m/op_q changes mid-transaction have no effect.
// - Asynchronous reset mid-transaction aborts immediately to reset values; no result is produced.
// - res_err: compare {hi,lo} against 14-bit m*q latched at accept; registered into DONE.
// TESTING
// - Reset asserted: chip_clk=1, chip_in=0, op_ready=1, res_valid=0, busy=0.
// - Reset deasserted: same values held until the first op_valid.
// - m=7'h7F, q=7'h7F with behavioural chip model, HALF_CYCLES=4 -> res_p=14'h3F01, res_err=0.
//   res_valid is high 25 cycles after accept.
// - m=0, q=7'h05 -> res_p=0, res_err=0.
// - m=7'h0C, q=7'h0A -> res_p=14'h0078.
// - Chip edge sequence: exactly falls at B and F entry and rises at D entry and DONE.
// - Chip model that swaps halves, m=7'h40 q=7'h40 -> res_p=14'h0020, res_err=1.
// - res_ready low for 10 cycles in DONE: res_valid, res_p and res_err stable; op_ready=0.
//   Then accept on res_ready=1; op_ready=1 on the next cycle.
// - rst_n pulsed low during state D: outputs return to reset values within the cycle;
//   a following op m=3, q=5 returns res_p=14'h000F.

Source files
------------

// File: rtl/mulu_m7q7_host_if.sv
// Operand/result handshake bundle between a test host and the 7x7 multiplier initiator.
interface mulu_m7q7_host_if;
    logic        op_valid;
    logic        op_ready;
    logic [6:0]  op_m;
    logic [6:0]  op_q;
    logic        res_valid;
    logic        res_ready;
    logic [13:0] res_p;
    logic        res_err;

    modport master (
        output op_valid, op_m, op_q, res_ready,
        input  op_ready, res_valid, res_p, res_err
    );

    modport slave (
        input  op_valid, op_m, op_q, res_ready,
        output op_ready, res_valid, res_p, res_err
    );
endinterface

// File: rtl/mulu_m7q7_host.sv
// Host-side initiator for the clock-edge-multiplexed 7x7 multiplier chip: sequences chip_clk
// and chip_in through the latch phases, captures both product halves and checks them.
module mulu_m7q7_host #(
    parameter int HALF_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mulu_m7q7_host_if.slave       bus,
    output logic                  chip_clk,
    output logic [6:0]            chip_in,
    input  logic [6:0]            chip_out,
    output logic                  busy
);

    localparam int CW = (HALF_CYCLES > 2) ? $clog2(HALF_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_A    = 3'd1,
        ST_B    = 3'd2,
        ST_C    = 3'd3,
        ST_D    = 3'd4,
        ST_E    = 3'd5,
        ST_F    = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          chip_clk_r;
    logic [6:0]    chip_in_r;
    logic [6:0]    m_r;
    logic [6:0]    q_r;
    logic [6:0]    lo_r;
    logic          op_ready_r;
    logic          res_valid_r;
    logic [13:0]   res_p_r;
    logic          res_err_r;
    logic          busy_r;
    logic [6:0]    sync_r [SYNC_STAGES];
    logic [6:0]    sample_s;
    logic          seg_end_s;

    function automatic logic [13:0] mul7(input logic [6:0] a, input logic [6:0] b);
        return {7'd0, a} * {7'd0, b};
    endfunction

    assign sample_s  = sync_r[SYNC_STAGES-1];
    assign seg_end_s = (cnt_r == CNT_ZERO);

    // chip_out is asynchronous to clk; resynchronise before any capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 7'd0;
        end else begin
            sync_r[0] <= chip_out;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    // Phase sequencer: every chip pin and handshake output comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            chip_clk_r  <= 1'b1;
            chip_in_r   <= 7'd0;
            m_r         <= 7'd0;
            q_r         <= 7'd0;
            lo_r        <= 7'd0;
            op_ready_r  <= 1'b1;
            res_valid_r <= 1'b0;
            res_p_r     <= 14'd0;
            res_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (state_r != ST_IDLE && state_r != ST_DONE) begin
                cnt_r <= seg_end_s ? CNT_LOAD : cnt_r - 1'b1;
            end else begin
                cnt_r <= CNT_LOAD;
            end
            case (state_r)
                ST_IDLE: begin
                    if (bus.op_valid && op_ready_r) begin
                        m_r        <= bus.op_m;
                        q_r        <= bus.op_q;
                        chip_in_r  <= bus.op_m;
                        chip_clk_r <= 1'b1;
                        op_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_A;
                    end else begin
                        op_ready_r <= !res_valid_r;
                    end
                end
                ST_A: begin
                    if (seg_end_s) begin
                        chip_clk_r <= 1'b0;
                        state_r    <= ST_B;
                    end
                end
                ST_B: begin
                    if (seg_end_s) begin
                        chip_in_r <= q_r;
                        state_r   <= ST_C;
                    end
                end
                ST_C: begin
                    if (seg_end_s) begin
                        chip_clk_r <= 1'b1;
                        state_r    <= ST_D;
                    end
                end
                ST_D: begin
                    if (seg_end_s) begin
                        lo_r      <= sample_s;
                        chip_in_r <= m_r;
                        state_r   <= ST_E;
                    end
                end
                ST_E: begin
                    if (seg_end_s) begin
                        chip_clk_r <= 1'b0;
                        state_r    <= ST_F;
                    end
                end
                ST_F: begin
                    if (seg_end_s) begin
                        chip_clk_r  <= 1'b1;
                        res_p_r     <= {sample_s, lo_r};
                        res_err_r   <= ({sample_s, lo_r} != mul7(m_r, q_r));
                        res_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        op_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    chip_clk_r  <= 1'b1;
                    res_valid_r <= 1'b0;
                    op_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign chip_clk      = chip_clk_r;
    assign chip_in       = chip_in_r;
    assign busy          = busy_r;
    assign bus.op_ready  = op_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_p     = res_p_r;
    assign bus.res_err   = res_err_r;

endmodule

// File: tb/tb_mulu_m7q7_host.sv
// Self-checking bench for mulu_m7q7_host with a behavioural model of the multiplexed chip.
module tb_mulu_m7q7_host;
    localparam int H = 4;
    localparam int LAT = 6 * H + 1;

    typedef struct packed { logic [13:0] p; logic err; } exp_t;
    typedef struct { longint t; logic v; } edge_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chip_clk;
    logic [6:0] chip_in;
    logic [6:0] chip_out;
    logic       busy;
    int         total = 0;
    int         bad = 0;
    bit         swap_mode = 1'b0;
    exp_t       exp_q[$];
    edge_t      clk_edges[$];
    longint     in_changes[$];
    longint     t_acc;
    logic [6:0] cm_m = 7'd0;
    logic [6:0] cm_q = 7'd0;
    logic [13:0] cm_p;

    mulu_m7q7_host_if bus();

    mulu_m7q7_host #(.HALF_CYCLES(H), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .chip_clk(chip_clk), .chip_in(chip_in), .chip_out(chip_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural chip: m on falling edge, q on rising edge, halves muxed by chip_clk level
    always @(negedge chip_clk) cm_m = chip_in;
    always @(posedge chip_clk) cm_q = chip_in;
    assign cm_p = {7'd0, cm_m} * {7'd0, cm_q};
    assign chip_out = (chip_clk ^ swap_mode) ? cm_p[6:0] : cm_p[13:7];

    always @(chip_clk) clk_edges.push_back('{$time, chip_clk});
    always @(chip_in) in_changes.push_back($time);

    task automatic start_op(input logic [6:0] m, input logic [6:0] q);
        logic [13:0] pt;
        logic [13:0] pe;
        int n;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_m = m; bus.op_q = q;
        n = 0;
        while (!bus.op_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.op_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout op_ready=%b required=1", bus.op_ready);
        end
        t_acc = $time + 5;
        pt = {7'd0, m} * {7'd0, q};
        pe = swap_mode ? {pt[6:0], pt[13:7]} : pt;
        exp_q.push_back('{pe, (pe != pt)});
    endtask

    task automatic wait_result(input bit hold_busy, output logic [13:0] p, output logic e,
                               output int lat, output bit to);
        lat = 0; to = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.op_valid = hold_busy; bus.op_m = 7'h01; bus.op_q = 7'h01;
            end
            if (bus.res_valid) begin lat = i; to = 1'b0; break; end
        end
        p = bus.res_p; e = bus.res_err;
        if (to) begin
            total++; bad++;
            $display("FAIL result_timeout res_valid=%b required=1", bus.res_valid);
        end
    endtask

    task automatic consume();
        @(negedge clk); bus.op_valid = 1'b0; bus.res_ready = 1'b1;
        @(negedge clk); bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total += 7;
        if (chip_clk !== 1'b1)      begin bad++; $display("FAIL rst_chip_clk got=%b want=1", chip_clk); end
        if (chip_in !== 7'd0)       begin bad++; $display("FAIL rst_chip_in got=%h want=00", chip_in); end
        if (bus.op_ready !== 1'b1)  begin bad++; $display("FAIL rst_op_ready got=%b want=1", bus.op_ready); end
        if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b want=0", bus.res_valid); end
        if (busy !== 1'b0)          begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (bus.res_p !== 14'd0)    begin bad++; $display("FAIL rst_res_p got=%h want=0000", bus.res_p); end
        if (bus.res_err !== 1'b0)   begin bad++; $display("FAIL rst_res_err got=%b want=0", bus.res_err); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({chip_clk, chip_in, bus.op_ready, bus.res_valid, busy} !== {1'b1, 7'd0, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL post_rst_hold clk=%b in=%h rdy=%b vld=%b busy=%b want 1/00/1/0/0",
                         chip_clk, chip_in, bus.op_ready, bus.res_valid, busy);
            end
        end
    endtask

    task automatic test_product(input string name, input logic [6:0] m, input logic [6:0] q,
                                input bit check_lat);
        logic [13:0] p; logic e; int lat; bit to; exp_t x;
        start_op(m, q);
        wait_result(1'b0, p, e, lat, to);
        x = exp_q.pop_front();
        if (!to) begin
            total += 2;
            if (p !== x.p) begin bad++; $display("FAIL %s_p got=%h want=%h", name, p, x.p); end
            if (e !== x.err) begin bad++; $display("FAIL %s_err got=%b want=%b", name, e, x.err); end
            if (check_lat) begin
                total++;
                if (lat != LAT) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, LAT); end
            end
        end
        consume();
    endtask

    task automatic test_edges();
        logic [13:0] p; logic e; int lat; bit to; exp_t x; int hits;
        longint offs [4] = '{40, 120, 200, 240};
        logic   dirs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        clk_edges.delete(); in_changes.delete();
        start_op(7'h15, 7'h2A);
        wait_result(1'b0, p, e, lat, to);
        x = exp_q.pop_front();
        total += 2;
        if (p !== x.p) begin bad++; $display("FAIL edges_p got=%h want=%h", p, x.p); end
        if (clk_edges.size() != 4) begin bad++; $display("FAIL edge_count got=%0d want=4", clk_edges.size()); end
        for (int i = 0; i < 4 && i < clk_edges.size(); i++) begin
            total++;
            if (clk_edges[i].t - t_acc != offs[i] || clk_edges[i].v !== dirs[i]) begin
                bad++;
                $display("FAIL edge_%0d got=(%0d,%b) want=(%0d,%b)", i, clk_edges[i].t - t_acc,
                         clk_edges[i].v, offs[i], dirs[i]);
            end
        end
        hits = 0;
        foreach (in_changes[j]) foreach (clk_edges[k]) if (in_changes[j] == clk_edges[k].t) hits++;
        total++;
        if (hits != 0) begin bad++; $display("FAIL in_clk_same_cycle got=%0d want=0", hits); end
        consume();
    endtask

    task automatic test_stall();
        logic [13:0] p; logic e; int lat; bit to; exp_t x;
        start_op(7'h33, 7'h21);
        wait_result(1'b1, p, e, lat, to);
        x = exp_q.pop_front();
        total += 2;
        if (p !== x.p) begin bad++; $display("FAIL stall_p got=%h want=%h", p, x.p); end
        if (e !== x.err) begin bad++; $display("FAIL stall_err got=%b want=%b", e, x.err); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({bus.res_valid, bus.res_p, bus.res_err, bus.op_ready} !== {1'b1, x.p, x.err, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold vld=%b p=%h err=%b rdy=%b want 1/%h/%b/0",
                         bus.res_valid, bus.res_p, bus.res_err, bus.op_ready, x.p, x.err);
            end
        end
        consume();
        total++;
        if ({bus.op_ready, bus.res_valid} !== 2'b10) begin
            bad++;
            $display("FAIL after_handshake rdy=%b vld=%b want 1/0", bus.op_ready, bus.res_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        start_op(7'h55, 7'h66);
        for (int i = 1; i <= 3 * H + 2; i++) begin
            @(negedge clk);
            if (i == 1) bus.op_valid = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({chip_clk, chip_in, bus.op_ready, bus.res_valid, busy, bus.res_p, bus.res_err} !==
            {1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset clk=%b in=%h rdy=%b vld=%b busy=%b p=%h err=%b",
                     chip_clk, chip_in, bus.op_ready, bus.res_valid, busy, bus.res_p, bus.res_err);
        end
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) begin @(negedge clk); if (bus.res_valid) seen = 1'b1; end
        total++;
        if (seen) begin bad++; $display("FAIL aborted_result res_valid seen=1 want=0"); end
        test_product("after_reset", 7'd3, 7'd5, 1'b1);
    endtask

    initial begin
        bus.op_valid = 1'b0; bus.op_m = 7'd0; bus.op_q = 7'd0; bus.res_ready = 1'b0;
        test_reset();
        test_product("max", 7'h7F, 7'h7F, 1'b1);
        test_product("zero", 7'h00, 7'h05, 1'b0);
        test_product("small", 7'h0C, 7'h0A, 1'b0);
        test_edges();
        swap_mode = 1'b1;
        test_product("swap", 7'h40, 7'h40, 1'b0);
        swap_mode = 1'b0;
        test_stall();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
